// File: rtl/brew_timer.sv
// Programmable countdown timer with prescaled tick, pause, one-shot/periodic modes
// and a sticky expiry flag. All outputs come straight from flops.
module brew_timer #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 8
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] value,
    output logic             running,
    output logic [WIDTH-1:0] remaining,
    output logic             texpired,
    output logic             expired_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             mode_q, mode_d;
    logic             texp_q, texp_d;
    logic             pulse_q, pulse_d;
    logic             running_q, running_d;

    // Next-state logic; branch order encodes stop > start > pause > tick.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        val_d   = val_q;
        mode_d  = mode_q;
        texp_d  = texp_q;
        pulse_d = 1'b0;
        if (stop) begin
            state_d = IDLE;
            pre_d   = {PW{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            texp_d  = 1'b0;
        end else if (start) begin
            pre_d  = {PW{1'b0}};
            val_d  = value;
            mode_d = mode;
            if (value == {WIDTH{1'b0}}) begin
                state_d = DONE;
                rem_d   = {WIDTH{1'b0}};
                texp_d  = 1'b1;
                pulse_d = 1'b1;
            end else begin
                state_d = RUN;
                rem_d   = value;
                texp_d  = 1'b0;
            end
        end else if ((state_q == RUN) || (state_q == PAUSED)) begin
            if (pause) begin
                state_d = PAUSED;
            end else begin
                // Leaving PAUSED resumes counting on the same edge.
                state_d = RUN;
                if (pre_q == PRE_LAST) begin
                    pre_d = {PW{1'b0}};
                    if (rem_q > WIDTH'(1)) begin
                        rem_d = rem_q - WIDTH'(1);
                    end else begin
                        texp_d  = 1'b1;
                        pulse_d = 1'b1;
                        if (mode_q) begin
                            rem_d = val_q;
                        end else begin
                            rem_d   = {WIDTH{1'b0}};
                            state_d = DONE;
                        end
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == RUN) || (state_d == PAUSED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= {PW{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            val_q     <= {WIDTH{1'b0}};
            mode_q    <= 1'b0;
            texp_q    <= 1'b0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            rem_q     <= rem_d;
            val_q     <= val_d;
            mode_q    <= mode_d;
            texp_q    <= texp_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
        end
    end

    assign running       = running_q;
    assign remaining     = rem_q;
    assign texpired      = texp_q;
    assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_brew_timer.sv
// Scoreboard bench for brew_timer: a cycle-count reference model pushes expected
// outputs per edge, a negedge monitor pops and compares.
module tb_brew_timer;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int WIDTH   = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, stop, pause, mode;
    logic [WIDTH-1:0] value;
    logic             running, texpired, expired_pulse;
    logic [WIDTH-1:0] remaining;

    brew_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH)) dut (
        .clk_100MHz(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .value(value), .running(running), .remaining(remaining),
        .texpired(texpired), .expired_pulse(expired_pulse)
    );

    typedef struct {
        logic             run;
        logic [WIDTH-1:0] rem;
        logic             texp;
        logic             pulse;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic last_pulse = 1'b0;

    // Reference model: counts clock cycles left until the next expiry.
    bit m_active = 1'b0, m_periodic = 1'b0, m_texp = 1'b0, m_pulse = 1'b0;
    int m_cyc = 0, m_period = 0, m_rem = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit pa,
                              input bit m, input int v);
        m_pulse = 1'b0;
        if (r) begin
            m_active = 1'b0; m_texp = 1'b0; m_rem = 0; m_cyc = 0; m_period = 0; m_periodic = 1'b0;
        end else if (p) begin
            m_active = 1'b0; m_texp = 1'b0; m_rem = 0;
        end else if (s) begin
            if (v == 0) begin
                m_active = 1'b0; m_texp = 1'b1; m_pulse = 1'b1; m_rem = 0;
            end else begin
                m_active = 1'b1; m_texp = 1'b0; m_periodic = m;
                m_period = v * DIV; m_cyc = m_period; m_rem = v;
            end
        end else if (m_active && !pa) begin
            m_cyc--;
            if (m_cyc == 0) begin
                m_texp = 1'b1; m_pulse = 1'b1;
                if (m_periodic) begin
                    m_cyc = m_period; m_rem = m_period / DIV;
                end else begin
                    m_active = 1'b0; m_rem = 0;
                end
            end else begin
                m_rem = (m_cyc + DIV - 1) / DIV;
            end
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit pa,
                         input bit m, input int v);
        exp_t e;
        rst = r; start = s; stop = p; pause = pa; mode = m; value = WIDTH'(v);
        @(posedge clk);
        model_step(r, s, p, pa, m, v);
        e.run = m_active; e.rem = WIDTH'(m_rem); e.texp = m_texp; e.pulse = m_pulse;
        sb_q.push_back(e);
        #1;
        last_pulse = expired_pulse;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("running",       int'(running),       int'(e.run));
            chk("remaining",     int'(remaining),     int'(e.rem));
            chk("texpired",      int'(texpired),      int'(e.texp));
            chk("expired_pulse", int'(expired_pulse), int'(e.pulse));
        end
    end

    // Start at edge 0, then run n edges with optional pause window, stop, restart, reset.
    task automatic run_scn(input int v, input int m, input int p_lo, input int p_hi,
                           input int stop_e, input int rs_e, input int rs_v,
                           input int rst_e, input int n,
                           output int first, output int cnt);
        first = -1;
        cnt   = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, m[0], v);
        for (int k = 1; k <= n; k++) begin
            bit r, s, p, pa, mm;
            int vv;
            r  = (k == rst_e);
            p  = (k == stop_e);
            s  = (k == rs_e);
            pa = (k >= p_lo) && (k <= p_hi);
            mm = 1'($urandom_range(0, 1));
            vv = s ? rs_v : int'($urandom_range(0, 15));
            drive(r, s, p, pa, mm, vv);
            if (last_pulse) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
    endtask

    initial begin
        int first, cnt;
        bit pa_lvl;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; value = '0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        run_scn(3, 0, -1, -2, -1, -1, 0, -1, 40, first, cnt);
        chk("oneshot_first_expiry_edge", first, 30);
        chk("oneshot_expiry_count", cnt, 1);
        chk("oneshot_pulse_falls", int'(expired_pulse), 0);
        chk("oneshot_texpired_held", int'(texpired), 1);

        run_scn(2, 1, -1, -2, -1, -1, 0, -1, 65, first, cnt);
        chk("periodic_first_expiry_edge", first, 20);
        chk("periodic_expiry_count", cnt, 3);
        chk("periodic_running", int'(running), 1);

        run_scn(3, 0, 12, 16, -1, -1, 0, -1, 45, first, cnt);
        chk("pause_expiry_edge", first, 35);

        run_scn(5, 0, -1, -2, 23, 30, 1, -1, 45, first, cnt);
        chk("stop_restart_expiry_edge", first, 40);
        chk("stop_restart_expiry_count", cnt, 1);

        run_scn(3, 0, -1, -2, -1, -1, 0, 15, 50, first, cnt);
        chk("rst_midrun_expiry_count", cnt, 0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk("zero_value_pulse", int'(last_pulse), 1);
        chk("zero_value_texpired", int'(texpired), 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7);
        chk("start_stop_same_cycle_running", int'(running), 0);

        pa_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r, s, p;
            int v;
            r = ($urandom_range(0, 299) == 0);
            p = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 14) == 0) pa_lvl = ~pa_lvl;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            drive(r, s, p, pa_lvl, 1'($urandom_range(0, 1)), v);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/brew_timer.md
BREW_TIMER -- requirements
Module: brew_timer

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count-tick frequency in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter WIDTH, default 8, width of the duration and remaining-count fields.
REQ-004 clk_100MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request: load value and begin counting.
REQ-007 stop  input  1  one-cycle abort request: return to idle.
REQ-008 pause  input  1  level; while high, counting is frozen.
REQ-009 mode  input  1  0 = one-shot, 1 = periodic; sampled with value on start.
REQ-010 value  input  WIDTH  duration in ticks; sampled only on accepted start.
REQ-011 running  output  1  high in RUN or PAUSED.
REQ-012 remaining  output  WIDTH  ticks left in the current period.
REQ-013 texpired  output  1  sticky expiry flag; cleared by start, stop or rst.
REQ-014 expired_pulse  output  1  one-cycle strobe per expiry.

Function
REQ-015 The prescaler SHALL count 0..(CLK_HZ/TICK_HZ - 1); an internal tick SHALL assert for one cycle at the terminal count.
REQ-016 The prescaler SHALL advance only in RUN with pause low, and SHALL be cleared on accepted start and on stop.
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSED and DONE; running = (RUN or PAUSED).
REQ-018 Same-cycle priority SHALL be rst > stop > start > pause > tick.
REQ-019 Accepted start in any state: latch value and mode, set remaining = value, clear texpired, go to RUN; a start in RUN or PAUSED restarts the timer.
REQ-020 A start with value == 0 SHALL go directly to DONE with texpired = 1, expired_pulse = 1 for the next cycle, and remaining = 0, regardless of mode.
REQ-021 In RUN, pause high SHALL move to PAUSED with no tick consumed; in PAUSED, pause low SHALL return to RUN with prescaler and remaining unchanged.
REQ-022 On a tick in RUN with remaining > 1: remaining decrements by 1.
REQ-023 On a tick in RUN with remaining == 1: remaining becomes 0 in one-shot, or the latched value in periodic; texpired becomes 1; expired_pulse is high for exactly the following cycle.
REQ-024 After an expiry, one-shot SHALL go to DONE; periodic SHALL stay in RUN and repeat indefinitely.
REQ-025 Expiry latency: with start accepted at edge E, the first expiry register update SHALL occur at edge E + value*(CLK_HZ/TICK_HZ).
REQ-026 stop SHALL go to IDLE, clear texpired and expired_pulse, and set remaining = 0.
REQ-027 DONE SHALL persist, holding texpired, until start, stop or rst.
REQ-028 value and mode changes outside an accepted start SHALL have no effect.
REQ-029 remaining SHALL never wrap below 0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst high at a clock edge SHALL force IDLE, prescaler = 0, remaining = 0, running = 0, texpired = 0, expired_pulse = 0, and clear the latched value and mode.
REQ-032 rst SHALL take precedence over every other input, including mid-count and in the cycle of an expiry.

Verification (CLK_HZ=10, TICK_HZ=1, WIDTH=4; start at edge 0)
REQ-033 start, value=3, mode=0 -> remaining 3,2,1,0 at edges 0,10,20,30; texpired and expired_pulse rise at edge 30; expired_pulse falls at edge 31; state DONE.
REQ-034 start, value=2, mode=1 -> expired_pulse at edges 20, 40 and 60; remaining reloads to 2 each time; running stays 1.
REQ-035 value=3, pause high during edges 12..16 -> remaining reaches 0 at edge 35 instead of 30.
REQ-036 value=5, stop at edge 23 -> IDLE, remaining 0, no expiry; new start at edge 30 with value=1 -> expiry at edge 40.
REQ-037 start with value=0 -> texpired 1 and expired_pulse 1 after edge 0, state DONE; a start and stop in the same cycle -> IDLE.
REQ-038 rst asserted at edge 15 of a value=3 run -> all outputs at reset values from edge 15; no expiry occurs afterwards.
